// File: rtl/board_io.sv
// Board I/O block: reset sequencer, switch synchronize/debounce with edge
// pulses, per-channel LED activity stretch, and bidirectional flash pads.
//
// Ports:
//   clk, rst         system clock, asynchronous active-high reset
//   pll_locked       PLL lock (async); rst_out is the released core reset
//   sw_in            raw switch pins; sw_out/sw_rise/sw_fall debounced
//   act_in           activity strobes; led is the LED drive
//   io/io_o/io_oe    flash pads, output data, output enable; io_i readback
//
// Macro BOARD_IO_LED_STRETCH_EN: when defined, each LED holds for
// 2^STRETCH_BITS-1 cycles after a strobe; otherwise led is act_in
// registered once.
module board_io #(
   parameter int LEDS          = 8,
   parameter int SWITCHES      = 4,
   parameter int QIO           = 4,
   parameter int DEBOUNCE_BITS = 16,
   parameter int STRETCH_BITS  = 22,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                pll_locked,
   output logic                rst_out,
   input  logic [SWITCHES-1:0] sw_in,
   output logic [SWITCHES-1:0] sw_out,
   output logic [SWITCHES-1:0] sw_rise,
   output logic [SWITCHES-1:0] sw_fall,
   input  logic [LEDS-1:0]     act_in,
   output logic [LEDS-1:0]     led,
   inout  wire  [QIO-1:0]      io,
   input  logic [QIO-1:0]      io_o,
   input  logic [QIO-1:0]      io_oe,
   output logic [QIO-1:0]      io_i
);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("board_io: SYNC_STAGES must be at least 2");
   end
   if (STRETCH_BITS < 1) begin : g_bad_stretch
      $error("board_io: STRETCH_BITS must be at least 1");
   end

   // ---------------------------------------------------------------
   // Reset sequencer. A low sample of pll_locked empties the chain at
   // once, so rst_out reasserts on the next edge and release needs
   // SYNC_STAGES fresh locked edges.
   // ---------------------------------------------------------------
   logic [SYNC_STAGES-1:0] rel_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rel_q <= '0;
      end else if (!pll_locked) begin
         rel_q <= '0;
      end else begin
         rel_q <= {rel_q[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign rst_out = ~rel_q[SYNC_STAGES-1];

   // ---------------------------------------------------------------
   // Switch synchronizer
   // ---------------------------------------------------------------
   logic [SWITCHES-1:0] sw_meta [SYNC_STAGES];
   logic [SWITCHES-1:0] sw_sync;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sw_meta[i] <= '0;
         end
      end else begin
         sw_meta[0] <= sw_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sw_meta[i] <= sw_meta[i-1];
         end
      end
   end

   assign sw_sync = sw_meta[SYNC_STAGES-1];

   // ---------------------------------------------------------------
   // Debounce: the counter measures how long the synchronized level has
   // disagreed with sw_out; the edge that would overflow it commits.
   // ---------------------------------------------------------------
   localparam logic [DEBOUNCE_BITS-1:0] DB_MAX = '1;
   localparam logic [DEBOUNCE_BITS-1:0] DB_ONE = DEBOUNCE_BITS'(1);

   logic [DEBOUNCE_BITS-1:0] db_cnt [SWITCHES];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < SWITCHES; b++) begin
            db_cnt[b] <= '0;
         end
         sw_out  <= '0;
         sw_rise <= '0;
         sw_fall <= '0;
      end else begin
         for (int b = 0; b < SWITCHES; b++) begin
            sw_rise[b] <= 1'b0;
            sw_fall[b] <= 1'b0;
            if (sw_sync[b] == sw_out[b]) begin
               db_cnt[b] <= '0;
            end else if (db_cnt[b] == DB_MAX) begin
               db_cnt[b]  <= '0;
               sw_out[b]  <= sw_sync[b];
               sw_rise[b] <= sw_sync[b];
               sw_fall[b] <= ~sw_sync[b];
            end else begin
               db_cnt[b] <= db_cnt[b] + DB_ONE;
            end
         end
      end
   end

   // ---------------------------------------------------------------
   // LED drive
   // ---------------------------------------------------------------
`ifdef BOARD_IO_LED_STRETCH_EN
   localparam logic [STRETCH_BITS-1:0] ST_MAX = '1;
   localparam logic [STRETCH_BITS-1:0] ST_ONE = STRETCH_BITS'(1);

   logic [STRETCH_BITS-1:0] st_cnt [LEDS];

   // A strobe always reloads, so a busy channel stays lit without wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < LEDS; c++) begin
            st_cnt[c] <= '0;
         end
      end else begin
         for (int c = 0; c < LEDS; c++) begin
            if (act_in[c]) begin
               st_cnt[c] <= ST_MAX;
            end else if (st_cnt[c] != '0) begin
               st_cnt[c] <= st_cnt[c] - ST_ONE;
            end
         end
      end
   end

   always_comb begin
      led = '0;
      for (int c = 0; c < LEDS; c++) begin
         led[c] = (st_cnt[c] != '0);
      end
   end
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led <= '0;
      end else begin
         led <= act_in;
      end
   end
`endif

   // ---------------------------------------------------------------
   // Flash pads; readback is raw, the consumer synchronizes.
   // ---------------------------------------------------------------
   for (genvar k = 0; k < QIO; k++) begin : g_pad
      assign io[k] = io_oe[k] ? io_o[k] : 1'bz;
   end

   assign io_i = io;

endmodule

// File: tb/tb_board_io.sv
// Testbench for board_io: directed scenarios plus randomized traffic
// checked against a history-based reference model.
module tb_board_io;

   localparam int LEDS = 8;
   localparam int SW   = 4;
   localparam int QIO  = 4;
   localparam int DBB  = 4;
   localparam int STB  = 3;
   localparam int SS   = 2;
   localparam int DB_N = 1 << DBB;
   localparam int ST_N = (1 << STB) - 1;

   logic            clk = 1'b0;
   logic            rst;
   logic            pll_locked;
   logic            rst_out;
   logic [SW-1:0]   sw_in;
   logic [SW-1:0]   sw_out;
   logic [SW-1:0]   sw_rise;
   logic [SW-1:0]   sw_fall;
   logic [LEDS-1:0] act_in;
   logic [LEDS-1:0] led;
   wire  [QIO-1:0]  io;
   logic [QIO-1:0]  io_o;
   logic [QIO-1:0]  io_oe;
   logic [QIO-1:0]  io_i;
   logic [QIO-1:0]  ext_drv;
   logic [QIO-1:0]  ext_en;

   int checks = 0;
   int errors = 0;

   board_io #(
      .LEDS(LEDS), .SWITCHES(SW), .QIO(QIO),
      .DEBOUNCE_BITS(DBB), .STRETCH_BITS(STB), .SYNC_STAGES(SS)
   ) dut (
      .clk(clk), .rst(rst), .pll_locked(pll_locked), .rst_out(rst_out),
      .sw_in(sw_in), .sw_out(sw_out), .sw_rise(sw_rise),
      .sw_fall(sw_fall), .act_in(act_in), .led(led), .io(io),
      .io_o(io_o), .io_oe(io_oe), .io_i(io_i)
   );

   for (genvar k = 0; k < QIO; k++) begin : g_ext
      assign io[k] = ext_en[k] ? ext_drv[k] : 1'bz;
   end

   always #5 clk = ~clk;

   // Reference model: edge index since reset, raw input history, and
   // the edge of the last committed change / last strobe per channel.
   int              n;
   logic [SW-1:0]   hist [$];
   int              last_chg [SW];
   int              last_act [LEDS];
   int              lock_run;
   logic [SW-1:0]   m_sw;
   logic [SW-1:0]   m_rise;
   logic [SW-1:0]   m_fall;
   logic [LEDS-1:0] m_led;

   task automatic model_reset();
      n = 0;
      hist.delete();
      for (int b = 0; b < SW; b++) last_chg[b] = 0;
      for (int c = 0; c < LEDS; c++) last_act[c] = 0;
      lock_run = 0;
      m_sw = '0;
      m_rise = '0;
      m_fall = '0;
      m_led = '0;
   endtask

   // Level seen by the debouncer at edge e: pin sampled SS edges earlier.
   function automatic logic [SW-1:0] syncd(int e);
      if (e < SS + 1) return '0;
      return hist[e-SS-1];
   endfunction

   task automatic model_edge();
      logic [SW-1:0] nxt;
      logic [SW-1:0] s;
      bit ok;
      nxt = m_sw;
      n++;
      hist.push_back(sw_in);
      for (int b = 0; b < SW; b++) begin
         if (n - last_chg[b] >= DB_N) begin
            ok = 1;
            for (int e = n - DB_N + 1; e <= n; e++) begin
               s = syncd(e);
               if (s[b] == m_sw[b]) ok = 0;
            end
            if (ok) begin
               nxt[b] = ~m_sw[b];
               last_chg[b] = n;
            end
         end
      end
      m_rise = nxt & ~m_sw;
      m_fall = ~nxt & m_sw;
      m_sw = nxt;
      if (pll_locked) lock_run = (lock_run < SS) ? lock_run + 1 : SS;
      else lock_run = 0;
      for (int c = 0; c < LEDS; c++) begin
         if (act_in[c]) last_act[c] = n;
`ifdef BOARD_IO_LED_STRETCH_EN
         m_led[c] = (last_act[c] > 0) && (n - last_act[c] < ST_N);
`else
         m_led[c] = act_in[c];
`endif
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst) model_edge();
      @(negedge clk);
   endtask

   task automatic do_reset();
      sw_in = '0;
      act_in = '0;
      pll_locked = 1'b1;
      rst = 1'b1;
      model_reset();
      tick();
      tick();
      rst = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset();
      sw_in = '0;
      act_in = '0;
      pll_locked = 1'b1;
      rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if (rst_out !== 1'b1 || sw_out !== '0 || sw_rise !== '0 ||
          sw_fall !== '0 || led !== '0) begin
         errors++;
         $display("FAIL reset_async: rst_out=%b sw_out=%h rise=%h fall=%h led=%h want 1/0/0/0/0",
                  rst_out, sw_out, sw_rise, sw_fall, led);
      end
      tick();
      tick();
      checks++;
      if (rst_out !== 1'b1 || sw_out !== '0 || led !== '0) begin
         errors++;
         $display("FAIL reset_held: rst_out=%b sw_out=%h led=%h want 1/0/0",
                  rst_out, sw_out, led);
      end
      rst = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         tick();
         checks++;
         if (rst_out !== (k < SS)) begin
            errors++;
            $display("FAIL rst_release edge %0d: got %b want %b",
                     k, rst_out, (k < SS));
         end
      end
   endtask

   task automatic test_pll_drop();
      logic exp_r;
      pll_locked = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         if (k == 1) pll_locked = 1'b1;
         exp_r = (k <= 2);
         checks++;
         if (rst_out !== exp_r) begin
            errors++;
            $display("FAIL pll_drop edge %0d: got %b want %b", k, rst_out, exp_r);
         end
      end
   endtask

   task automatic test_debounce();
      do_reset();
      sw_in[0] = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         checks++;
         if (sw_out[0] !== (k >= SS + DB_N) ||
             sw_rise[0] !== (k == SS + DB_N) || sw_fall[0] !== 1'b0) begin
            errors++;
            $display("FAIL deb_rise edge %0d: out=%b rise=%b fall=%b want %b/%b/0",
                     k, sw_out[0], sw_rise[0], sw_fall[0],
                     (k >= SS + DB_N), (k == SS + DB_N));
         end
      end
      sw_in[0] = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         checks++;
         if (sw_out[0] !== (k < SS + DB_N) ||
             sw_fall[0] !== (k == SS + DB_N) || sw_rise[0] !== 1'b0) begin
            errors++;
            $display("FAIL deb_fall edge %0d: out=%b rise=%b fall=%b", k,
                     sw_out[0], sw_rise[0], sw_fall[0]);
         end
      end
   endtask

   task automatic test_glitch();
      sw_in[1] = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         tick();
         if (k == DB_N - 1) sw_in[1] = 1'b0;
         checks++;
         if (sw_out[1] !== 1'b0 || sw_rise[1] !== 1'b0 || sw_fall[1] !== 1'b0) begin
            errors++;
            $display("FAIL glitch edge %0d: out=%b rise=%b fall=%b want 0/0/0",
                     k, sw_out[1], sw_rise[1], sw_fall[1]);
         end
      end
   endtask

   task automatic test_led();
      logic [LEDS-1:0] exp_l;
      do_reset();
`ifdef BOARD_IO_LED_STRETCH_EN
      for (int k = 1; k <= 10; k++) begin
         act_in[2] = (k == 1);
         tick();
         exp_l = '0;
         exp_l[2] = (k <= ST_N);
         checks++;
         if (led !== exp_l) begin
            errors++;
            $display("FAIL led_single edge %0d: got %h want %h", k, led, exp_l);
         end
      end
      for (int k = 1; k <= 14; k++) begin
         act_in[2] = (k == 1) || (k == 5);
         tick();
         exp_l = '0;
         exp_l[2] = (k <= 4 + ST_N);
         checks++;
         if (led !== exp_l) begin
            errors++;
            $display("FAIL led_retrig edge %0d: got %h want %h", k, led, exp_l);
         end
      end
      act_in = '0;
`else
      for (int k = 1; k <= 3; k++) begin
         act_in = (k == 1) ? 8'hA5 : 8'h00;
         tick();
         exp_l = (k == 1) ? 8'hA5 : 8'h00;
         checks++;
         if (led !== exp_l) begin
            errors++;
            $display("FAIL led_reg edge %0d: got %h want %h", k, led, exp_l);
         end
      end
      act_in = '0;
`endif
   endtask

   task automatic test_io();
      logic [QIO-1:0] exp_io;
      for (int k = 0; k < 8; k++) begin
         if (k < 4) begin
            io_oe = 4'b0011;
            io_o = 4'b1010;
         end else begin
            io_oe = QIO'($urandom);
            io_o = QIO'($urandom);
         end
         ext_en = ~io_oe;
         ext_drv = QIO'($urandom);
         #1;
         exp_io = (io_oe & io_o) | (~io_oe & ext_drv);
         checks++;
         if (io_i !== exp_io) begin
            errors++;
            $display("FAIL io_pad %0d: got %b want %b (oe=%b o=%b ext=%b)",
                     k, io_i, exp_io, io_oe, io_o, ext_drv);
         end
      end
   endtask

   task automatic test_rst_mid_debounce();
      do_reset();
      sw_in[2] = 1'b1;
      for (int k = 0; k < 10; k++) tick();
      rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if (sw_out !== '0 || sw_rise !== '0 || sw_fall !== '0 || rst_out !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid: out=%h rise=%h fall=%h rst_out=%b want 0/0/0/1",
                  sw_out, sw_rise, sw_fall, rst_out);
      end
      tick();
      rst = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         checks++;
         if (sw_out[2] !== (k >= SS + DB_N) || sw_rise[2] !== (k == SS + DB_N)) begin
            errors++;
            $display("FAIL rst_mid_redeb edge %0d: out=%b rise=%b want %b/%b", k,
                     sw_out[2], sw_rise[2], (k >= SS + DB_N), (k == SS + DB_N));
         end
      end
   endtask

   task automatic test_random();
      logic [QIO-1:0] exp_io;
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         exp_io = (io_oe & io_o) | (~io_oe & ext_drv);
         checks++;
         if (rst_out !== (lock_run < SS)) begin
            errors++;
            $display("FAIL rnd_rst_out cyc %0d: got %b want %b", cyc, rst_out,
                     (lock_run < SS));
         end
         checks++;
         if (sw_out !== m_sw || sw_rise !== m_rise || sw_fall !== m_fall) begin
            errors++;
            $display("FAIL rnd_sw cyc %0d: out=%h rise=%h fall=%h want %h/%h/%h",
                     cyc, sw_out, sw_rise, sw_fall, m_sw, m_rise, m_fall);
         end
         checks++;
         if (led !== m_led) begin
            errors++;
            $display("FAIL rnd_led cyc %0d: got %h want %h", cyc, led, m_led);
         end
         checks++;
         if (io_i !== exp_io) begin
            errors++;
            $display("FAIL rnd_io cyc %0d: got %b want %b", cyc, io_i, exp_io);
         end
         for (int b = 0; b < SW; b++) begin
            if ($urandom_range(29) == 0) sw_in[b] = ~sw_in[b];
         end
         for (int c = 0; c < LEDS; c++) begin
            act_in[c] = ($urandom_range(11) == 0);
         end
         if (pll_locked) pll_locked = ($urandom_range(199) != 0);
         else pll_locked = ($urandom_range(2) == 0);
         io_oe = QIO'($urandom);
         io_o = QIO'($urandom);
         ext_en = ~io_oe;
         ext_drv = QIO'($urandom);
         if (!rst && $urandom_range(399) == 0) begin
            rst = 1'b1;
            model_reset();
         end else begin
            rst = 1'b0;
         end
         tick();
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      pll_locked = 1'b1;
      sw_in = '0;
      act_in = '0;
      io_o = '0;
      io_oe = '0;
      ext_en = '1;
      ext_drv = '0;
      model_reset();
      @(negedge clk);
      test_reset();
      test_pll_drop();
      test_debounce();
      test_glitch();
      test_led();
      test_io();
      test_rst_mid_debounce();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/board_io.md
BOARD_IO -- requirements
Module: board_io

Interface
REQ-001 Parameter LEDS, default 8: number of LED channels.
REQ-002 Parameter SWITCHES, default 4: number of debounced switch inputs.
REQ-003 Parameter QIO, default 4: number of bidirectional flash pad bits.
REQ-004 Parameter DEBOUNCE_BITS, default 16: debounce counter width.
REQ-005 Parameter STRETCH_BITS, default 22: LED stretch counter width.
REQ-006 Parameter SYNC_STAGES, default 2, minimum 2: reset release and input synchronizer depth.
REQ-007 clk  in  1  single system clock; all logic is on its rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 pll_locked  in  1  PLL lock indicator, asynchronous to clk.
REQ-010 rst_out  out  1  active-high core reset, synchronously released.
REQ-011 sw_in  in  SWITCHES  raw switch pins, asynchronous.
REQ-012 sw_out  out  SWITCHES  debounced switch levels.
REQ-013 sw_rise, sw_fall  out  SWITCHES each  one-cycle edge pulses of sw_out.
REQ-014 act_in  in  LEDS  per-channel activity strobes, clk domain.
REQ-015 led  out  LEDS  LED drive, active-high.
REQ-016 io  inout  QIO  flash pads; io_o  in  QIO; io_oe  in  QIO; io_i  out  QIO.

Function
REQ-017 Reset sequencer: rst_out forced 1 whenever rst=1 or pll_locked has been sampled 0; it goes 0 only after SYNC_STAGES consecutive edges with pll_locked=1 and rst=0.
REQ-018 pll_locked falling mid-operation: rst_out returns to 1 within SYNC_STAGES edges and stays 1 until the full release sequence repeats.
REQ-019 Each sw_in bit passes through a SYNC_STAGES-flop synchronizer before debounce.
REQ-020 Debounce per bit: counter cleared whenever synchronized value equals sw_out; incremented on each edge where it differs.
REQ-021 On the edge where counter = 2^DEBOUNCE_BITS-1 and the mismatch persists, sw_out takes the synchronized value and the counter clears; sw_out changes after exactly 2^DEBOUNCE_BITS consecutive mismatch cycles.
REQ-022 Any single-cycle return to match before the threshold clears the counter; no change on sw_out.
REQ-023 sw_rise (sw_fall) is 1 for exactly the one cycle after sw_out goes 0->1 (1->0); never both on one bit.
REQ-024 LED stretch per channel: act_in=1 at an edge loads counter with 2^STRETCH_BITS-1; otherwise a nonzero counter decrements by 1, saturating at 0.
REQ-025 led = (counter != 0); a single-cycle strobe yields exactly 2^STRETCH_BITS-1 cycles of led=1; strobes while lit reload (retrigger), no wrap-around.
REQ-026 Pads: io[k] driven with io_o[k] when io_oe[k]=1, high-impedance otherwise; io_i = io (combinational, unregistered; synchronization is the consumer's duty).
REQ-027 Channels are independent; simultaneous events on different bits never interact.

Reset
REQ-028 rst=1 asynchronously sets: rst_out=1, all synchronizer flops 0, sw_out=0, sw_rise=sw_fall=0, all counters 0, led=0.
REQ-029 rst is not gated by pll_locked; rst_out is the only output reflecting pll_locked.
REQ-030 Release of rst does not produce sw_rise/sw_fall pulses; a switch already high is reported only after the full debounce interval.

Configuration
REQ-031 Macro BOARD_IO_LED_STRETCH_EN defined: stretch counters present per REQ-024/025.
REQ-032 Macro undefined: no stretch counters; led is act_in registered once (one-cycle latency, equal pulse width); STRETCH_BITS ignored.

Verification
REQ-033 SYNC_STAGES=2: rst 1->0 with pll_locked=1 -> rst_out falls on 2nd edge; drop pll_locked 1 cycle -> rst_out=1 within 2 edges, release 2 edges after lock returns.
REQ-034 DEBOUNCE_BITS=4: sw_in[0] 0->1 held -> sw_out[0]=1 exactly 2+16 edges later, sw_rise[0] one cycle, sw_fall stays 0.
REQ-035 DEBOUNCE_BITS=4: sw_in[1] glitch high for 15 cycles -> sw_out[1] stays 0, no pulses.
REQ-036 STRETCH_BITS=3, macro defined: act_in[2] one cycle -> led[2] high exactly 7 cycles; second strobe at cycle 5 -> high until 7 cycles after it.
REQ-037 Macro undefined: act_in=8'hA5 one cycle -> led=8'hA5 next cycle only, then 0.
REQ-038 io_oe=4'b0011, io_o=4'b1010 -> pads 1:0 read 2'b10 on io_i; pads 3:2 high-Z and io_i follows external drive; rst asserted mid-debounce -> sw_out=0, counters 0.
